// File: rtl/led_pkg.sv
// Shared constants and types for the multiplexed LED scan controller.
package led_pkg;

   localparam int N_DIG = 8;
   localparam int DIG_W = 5;

   typedef logic [DIG_W-1:0] dig_code_t;

   localparam dig_code_t CODE_ALL_ON = 5'h1F;
   localparam dig_code_t CODE_RESET  = 5'h00;

   typedef enum logic {BLANK, DRIVE} scan_state_t;

endpackage

// File: rtl/led_scan_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic a_req,
   input  logic b_req,
   output logic a_gnt,
   output logic b_gnt
);

   // last_b=1 means B won most recently, so A takes the next tie
   logic last_b;

   always_comb begin
      a_gnt = a_req & (~b_req | last_b);
      b_gnt = b_req & (~a_req | ~last_b);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_b <= 1'b1;
      else if (a_gnt) last_b <= 1'b0;
      else if (b_gnt) last_b <= 1'b1;
   end

endmodule

// File: rtl/led_scan_ctrl.sv
// 8-digit LED scan controller with blanking gap and round-robin buffer writes.
// Optional LED_SCAN_CTRL_LAMP_TEST_EN adds a lamp_test input forcing all segments on.
module led_scan_ctrl
   import led_pkg::*;
#(
   parameter int F_CLK     = 50000000,
   parameter int F_SCAN    = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [2:0]        a_addr,
   input  logic [DIG_W-1:0]  a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [2:0]        b_addr,
   input  logic [DIG_W-1:0]  b_data,
   output logic              b_ready,
`ifdef LED_SCAN_CTRL_LAMP_TEST_EN
   input  logic              lamp_test,
`endif
   output logic [N_DIG-1:0]  cs,
   output logic [DIG_W-1:0]  dig_ctrl,
   output logic              frame_done
);

   localparam int DIV = F_CLK / F_SCAN;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(BLANK_CYC + 1) + 1;

   generate
      if (BLANK_CYC < 1 || BLANK_CYC >= DIV) begin : g_bad_cfg
         $error("led_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < F_CLK/F_SCAN");
      end
   endgenerate

   scan_state_t      state_q, state_d;
   logic [TW-1:0]    tick;
   logic [BW-1:0]    bcnt;
   logic [2:0]       ptr;
   logic [N_DIG-1:0] cs_q;
   dig_code_t        dig_q;
   dig_code_t        dig_buf [N_DIG];
   logic             tick_wrap, load, leave;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .a_req (a_valid),
      .b_req (b_valid),
      .a_gnt (a_ready),
      .b_gnt (b_ready)
   );

   assign tick_wrap = (tick == TW'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         tick <= '0;
      else if (tick_wrap) tick <= '0;
      else                tick <= tick + TW'(1);
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      leave   = 1'b0;
      case (state_q)
         BLANK: if (bcnt == BW'(BLANK_CYC - 1)) begin
            state_d = DRIVE;
            load    = 1'b1;
         end
         DRIVE: if (tick_wrap) begin
            state_d = BLANK;
            leave   = 1'b1;
         end
         default: state_d = BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BLANK;
         bcnt       <= '0;
         ptr        <= '0;
         cs_q       <= '1;
         dig_q      <= CODE_ALL_ON;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_done <= leave && (ptr == 3'd7);
         if (leave)                 bcnt <= '0;
         else if (state_q == BLANK) bcnt <= bcnt + BW'(1);
         if (leave) ptr <= ptr + 3'd1;
         // the load sees the buffer before this edge's write lands
         if (load) begin
            cs_q  <= N_DIG'(1) << ptr;
            dig_q <= dig_buf[ptr];
         end else if (state_q == BLANK || leave) begin
            cs_q  <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIG; i++) dig_buf[i] <= CODE_RESET;
      end else if (a_ready) begin
         dig_buf[a_addr] <= a_data;
      end else if (b_ready) begin
         dig_buf[b_addr] <= b_data;
      end
   end

`ifdef LED_SCAN_CTRL_LAMP_TEST_EN
   logic lamp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lamp_q <= 1'b0;
      else        lamp_q <= lamp_test;
   end

   assign cs       = lamp_q ? '1 : cs_q;
   assign dig_ctrl = lamp_q ? CODE_ALL_ON : dig_q;
`else
   assign cs       = cs_q;
   assign dig_ctrl = dig_q;
`endif

endmodule
